// File: rtl/mm_pkg.sv
// Shared definitions for the 2x2 matrix multiplier datapath and its result serializer.
package mm_pkg;

    localparam int unsigned ELEM_W      = 4;
    localparam int unsigned RES_W       = 2 * ELEM_W + 1;
    localparam int unsigned FRAME_BYTES = 8;
    localparam int unsigned IDX_W       = 3;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_e;

    // Sign-extend the low w bits of v to 16 bits.
    function automatic logic [15:0] sext16(input logic [15:0] v, input int unsigned w);
        logic [15:0] r;
        r = v;
        for (int unsigned i = 0; i < 16; i++) begin
            if (i >= w) r[4'(i)] = v[4'(w - 1)];
        end
        return r;
    endfunction

endpackage

// File: rtl/mm_result_serializer.sv
// Buffers one 2x2 result matrix and streams it as an 8-byte little-endian frame
// (c00, c01, c10, c11, each sign-extended to 16 bits) over a valid/ready byte port.
module mm_result_serializer
    import mm_pkg::*;
#(
    parameter int unsigned ELEM_W = mm_pkg::ELEM_W,
    parameter int unsigned RES_W  = 2 * ELEM_W + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [4*RES_W-1:0] in_c,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [7:0]         out_data,
    output logic               out_first,
    output logic               out_last,
    output logic [7:0]         frame_cnt
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_BYTES - 1);

    if (RES_W > 16) begin : g_bad_res_w
        $error("mm_result_serializer: RES_W must be <= 16");
    end

    state_e               state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [4*RES_W-1:0]   frame_q, frame_d;
    logic [7:0]           cnt_q, cnt_d;
    logic                 out_valid_q, out_valid_d;
    logic [7:0]           out_data_q, out_data_d;
    logic                 out_first_q, out_first_d;
    logic                 out_last_q, out_last_d;

    // Byte k of a frame: element k/2, low half when k is even.
    function automatic logic [7:0] frame_byte(input logic [4*RES_W-1:0] f,
                                              input logic [IDX_W-1:0]   k);
        logic [RES_W-1:0] e;
        logic [15:0]      s;
        case (k[2:1])
            2'd0:    e = f[RES_W-1:0];
            2'd1:    e = f[2*RES_W-1:RES_W];
            2'd2:    e = f[3*RES_W-1:2*RES_W];
            default: e = f[4*RES_W-1:3*RES_W];
        endcase
        s = sext16(16'(e), RES_W);
        return k[0] ? s[15:8] : s[7:0];
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            frame_q     <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_first_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            frame_q     <= frame_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_first_q <= out_first_d;
            out_last_q  <= out_last_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        frame_d  = frame_q;
        cnt_d    = cnt_q;
        in_ready = 1'b0;

        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    frame_d = in_c;
                    idx_d   = '0;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (out_ready) begin
                    if (idx_q == LAST_IDX) begin
                        // Last byte leaves: refill in the same edge to avoid a bubble.
                        cnt_d    = cnt_q + 8'd1;
                        in_ready = 1'b1;
                        if (in_valid) begin
                            frame_d = in_c;
                            idx_d   = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            default: ;
        endcase

        // Output flops are loaded from next state so they track state with no extra cycle.
        out_valid_d = (state_d == SEND);
        out_data_d  = out_valid_d ? frame_byte(frame_d, idx_d) : 8'h00;
        out_first_d = out_valid_d && (idx_d == '0);
        out_last_d  = out_valid_d && (idx_d == LAST_IDX);
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_first = out_first_q;
    assign out_last  = out_last_q;
    assign frame_cnt = cnt_q;

endmodule

// File: tb/tb_mm_result_serializer.sv
// Directed bench for mm_result_serializer with a byte scoreboard fed at matrix acceptance.
module tb_mm_result_serializer;
    import mm_pkg::*;

    localparam int unsigned RW = mm_pkg::RES_W;

    typedef struct packed {
        logic [7:0] data;
        logic       first;
        logic       last;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [4*RW-1:0] in_c;
    logic            out_valid;
    logic            out_ready;
    logic [7:0]      out_data;
    logic            out_first;
    logic            out_last;
    logic [7:0]      frame_cnt;

    exp_t q[$];
    int   cur[4];
    int   checks = 0;
    int   errors = 0;
    int   exp_cnt = 0;

    mm_result_serializer dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_c      (in_c),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_first (out_first),
        .out_last  (out_last),
        .frame_cnt (frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] exp_byte(input int v, input int half);
        logic [15:0] s;
        s = 16'(v);
        return (half != 0) ? s[15:8] : s[7:0];
    endfunction

    function automatic logic [4*RW-1:0] pack_cur();
        return {RW'(cur[3]), RW'(cur[2]), RW'(cur[1]), RW'(cur[0])};
    endfunction

    task automatic push_frame();
        exp_t e;
        for (int k = 0; k < 8; k++) begin
            e.data  = exp_byte(cur[k/2], k % 2);
            e.first = (k == 0);
            e.last  = (k == 7);
            q.push_back(e);
        end
    endtask

    task automatic set_rand();
        for (int i = 0; i < 4; i++) cur[i] = int'($urandom_range(0, 511)) - 256;
        in_c = pack_cur();
    endtask

    // Present cur until accepted; returns at acceptance edge + 1.
    task automatic send_matrix();
        logic acc;
        acc = 1'b0;
        in_valid = 1'b1;
        in_c = pack_cur();
        for (int i = 0; i < 40 && !acc; i++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
        end
        check("accept", 32'(acc), 32'd1);
        if (acc) push_frame();
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && q.size() != 0; i++) @(posedge clk);
        #1;
        check("drain", 32'(q.size()), 32'd0);
    endtask

    // Hold in_valid high with random matrices for n frames, measuring gaps and accept spacing.
    task automatic stream(input int n, output int gaps, output int bad_space);
        int   acc_n;
        int   last_cyc;
        logic a;
        acc_n = 0;
        last_cyc = 0;
        gaps = 0;
        bad_space = 0;
        in_valid = 1'b1;
        set_rand();
        for (int cyc = 0; cyc < n * 8 + 40; cyc++) begin
            @(negedge clk);
            if (acc_n > 0 && out_valid !== 1'b1) gaps++;
            a = in_ready && in_valid;
            @(posedge clk);
            if (a) begin
                push_frame();
                if (acc_n > 0 && cyc - last_cyc != 8) bad_space++;
                last_cyc = cyc;
                acc_n++;
                #1;
                if (acc_n < n) set_rand();
                else in_valid = 1'b0;
            end
            if (acc_n == n && q.size() == 0) break;
        end
        #1;
        check("stream_done", 32'(acc_n), 32'(n));
        check("stream_queue", 32'(q.size()), 32'd0);
    endtask

    // Scoreboard consumer: every accepted byte must match the next expected byte.
    always @(negedge clk) begin
        if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL unexpected_byte: observed 0x%0h expected none", out_data);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("byte", 32'({out_data, out_first, out_last}), 32'(e));
            end
        end
    end

    initial begin
        int         gaps;
        int         bad;
        logic [9:0] held;

        rst = 1'b1;
        in_valid = 1'b0;
        in_c = '0;
        out_ready = 1'b0;
        #3;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_first_last", 32'({out_first, out_last}), 32'd0);
        check("rst_frame_cnt", 32'(frame_cnt), 32'd0);

        // No capture while reset is held.
        cur = '{1, 2, 3, 4};
        in_c = pack_cur();
        in_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_no_capture", 32'(out_valid), 32'd0);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("idle_after_rst", 32'(out_valid), 32'd0);

        // All results 8, full throughput, latency of one cycle.
        out_ready = 1'b1;
        cur = '{8, 8, 8, 8};
        send_matrix();
        check("latency_byte0", 32'({out_valid, out_first, out_data}), 32'({1'b1, 1'b1, 8'h08}));
        drain();
        exp_cnt++;
        check("cnt_frame1", 32'(frame_cnt), 32'(8'(exp_cnt)));
        check("idle_after_frame", 32'(out_valid), 32'd0);

        // out_ready high in IDLE does nothing.
        repeat (3) @(posedge clk);
        #1;
        check("idle_ready_valid", 32'(out_valid), 32'd0);
        check("idle_ready_cnt", 32'(frame_cnt), 32'(8'(exp_cnt)));

        // Sign-extension boundaries.
        cur = '{-3, 255, -256, 0};
        send_matrix();
        drain();
        exp_cnt++;
        check("cnt_frame2", 32'(frame_cnt), 32'(8'(exp_cnt)));

        // Backpressure on byte 2 for three cycles.
        cur = '{-1, 100, -100, 7};
        send_matrix();
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        held = {out_data, out_first, out_last};
        check("bp_byte2", 32'(held), 32'({exp_byte(100, 0), 1'b0, 1'b0}));
        repeat (3) begin
            @(posedge clk);
            #1;
            check("bp_hold", 32'({out_valid, out_data, out_first, out_last}), 32'({1'b1, held}));
            check("bp_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        drain();
        exp_cnt++;
        check("cnt_bp", 32'(frame_cnt), 32'(8'(exp_cnt)));

        // Back-to-back pair with in_valid held high.
        stream(2, gaps, bad);
        exp_cnt += 2;
        check("b2b_gaps", 32'(gaps), 32'd0);
        check("b2b_spacing", 32'(bad), 32'd0);
        check("cnt_b2b", 32'(frame_cnt), 32'(8'(exp_cnt)));

        // Reset on byte 4 aborts the frame.
        set_rand();
        send_matrix();
        repeat (4) @(posedge clk);
        #1;
        check("pre_rst_byte4", 32'({out_data, out_first, out_last}), 32'({exp_byte(cur[2], 0), 1'b0, 1'b0}));
        rst = 1'b1;
        #1;
        check("async_rst_outs", 32'({out_valid, out_data, out_first, out_last}), 32'd0);
        check("async_rst_in_ready", 32'(in_ready), 32'd1);
        q.delete();
        exp_cnt = 0;
        check("rst_cnt", 32'(frame_cnt), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_idle", 32'(out_valid), 32'd0);
        set_rand();
        send_matrix();
        check("post_rst_first", 32'(out_first), 32'd1);
        drain();
        exp_cnt++;
        check("cnt_post_rst", 32'(frame_cnt), 32'(8'(exp_cnt)));

        // 255 more frames take the count through 255 back to 0.
        stream(255, gaps, bad);
        exp_cnt += 255;
        check("wrap_gaps", 32'(gaps), 32'd0);
        check("wrap_spacing", 32'(bad), 32'd0);
        check("cnt_wrap", 32'(frame_cnt), 32'(8'(exp_cnt)));
        check("cnt_wrap_zero", 32'(frame_cnt), 32'd0);

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
